// File: rtl/fetch_packer.sv
// fetch_packer: producer side of the instruction-queue fill interface.
// Takes one fetched line of TABLESIZE words, tags each word with its PC and
// emits it as aligned {PC, instr} tables cut to the room the queue reports.
// A redirect (i_flush) replaces everything with a flush token (cut 0xFF).
// Optional: define FETCH_PACKER_NOPPAD_EN to pad unused entries with a nop
// (64'h13) instead of zero; the flush token table stays all-zero.
module fetch_packer #(
    parameter int TABLESIZE = 10,
    parameter int ENTRYW    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_lineValid,
    output logic                          o_lineReady,
    input  logic [32*TABLESIZE-1:0]       i_lineData,
    input  logic [31:0]                   i_linePC,
    input  logic [3:0]                    i_startOffset,
    input  logic                          i_flush,
    input  logic [7:0]                    i_room,
    output logic                          o_tableValid,
    input  logic                          i_tableReady,
    output logic [ENTRYW*TABLESIZE-1:0]   o_alignedInstructionTable,
    output logic [7:0]                    o_cutPostion_8
);

`ifdef FETCH_PACKER_NOPPAD_EN
    localparam logic [ENTRYW-1:0] PAD = ENTRYW'(64'h0000_0000_0000_0013);
`else
    localparam logic [ENTRYW-1:0] PAD = '0;
`endif
    localparam logic [7:0] TS = 8'(TABLESIZE);

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;

    state_t                        state, state_nxt;
    logic [32*TABLESIZE-1:0]       line_data;
    logic [31:0]                   line_pc;
    logic [7:0]                    cursor;
    logic [7:0]                    cursor_after;
    logic [7:0]                    room_c;
    logic [7:0]                    remain;
    logic [7:0]                    n_load;
    logic                          hs;
    logic                          load;
    logic [ENTRYW*TABLESIZE-1:0]   chunk;

    assign hs     = o_tableValid & i_tableReady;
    assign room_c = (i_room > TS) ? TS : i_room;

    // Chunk bookkeeping: cursor advances past the chunk consumed this edge,
    // and the next chunk is sized from that advanced cursor.
    always_comb begin
        cursor_after = cursor;
        if (state == EMIT && hs)
            cursor_after = cursor + o_cutPostion_8 + 8'd1;
        remain = TS - cursor_after;
        n_load = (remain < room_c) ? remain : room_c;
        load   = (state == EMIT) && (!o_tableValid || hs) &&
                 (cursor_after < TS) && (room_c != 8'd0);
    end

    // Build the candidate aligned table from the latched line.
    always_comb begin
        logic [31:0] idx;
        chunk = '0;
        idx   = '0;
        for (int unsigned j = 0; j < TABLESIZE; j++) begin
            idx = 32'(cursor_after) + j;
            if (j < 32'(n_load))
                chunk[ENTRYW*j +: ENTRYW] = ENTRYW'({line_pc + (idx << 2), line_data[idx*32 +: 32]});
            else
                chunk[ENTRYW*j +: ENTRYW] = PAD;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; flush outranks everything except a pending token.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (i_flush) state_nxt = FLUSH;
                   else if (i_lineValid) state_nxt = EMIT;
            EMIT:  if (i_flush) state_nxt = FLUSH;
                   else if (cursor_after >= TS) state_nxt = IDLE;
            FLUSH: if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: line handshake readiness.
    always_comb begin
        o_lineReady = (state == IDLE) && !i_flush;
    end

    // Datapath: line latch, cursor and the registered table/cut/valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_data                 <= '0;
            line_pc                   <= '0;
            cursor                    <= '0;
            o_tableValid              <= 1'b0;
            o_alignedInstructionTable <= '0;
            o_cutPostion_8            <= 8'hFF;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_flush) begin
                        o_alignedInstructionTable <= '0;
                        o_cutPostion_8            <= 8'hFF;
                        o_tableValid              <= 1'b1;
                    end else if (i_lineValid) begin
                        line_data <= i_lineData;
                        line_pc   <= i_linePC;
                        cursor    <= {4'b0, i_startOffset};
                    end
                end
                EMIT: begin
                    if (i_flush) begin
                        o_alignedInstructionTable <= '0;
                        o_cutPostion_8            <= 8'hFF;
                        o_tableValid              <= 1'b1;
                    end else begin
                        cursor <= cursor_after;
                        if (load) begin
                            o_alignedInstructionTable <= chunk;
                            o_cutPostion_8            <= n_load - 8'd1;
                            o_tableValid              <= 1'b1;
                        end else if (hs) begin
                            o_tableValid <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Re-asserted flush keeps the single pending token.
                    if (hs) o_tableValid <= 1'b0;
                end
                default: o_tableValid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_packer.sv
// Directed testbench for fetch_packer.
module tb_fetch_packer;

    localparam int TS = 10;
`ifdef FETCH_PACKER_NOPPAD_EN
    localparam logic [63:0] PAD = 64'h0000_0000_0000_0013;
`else
    localparam logic [63:0] PAD = 64'h0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_lineValid;
    logic              o_lineReady;
    logic [32*TS-1:0]  i_lineData;
    logic [31:0]       i_linePC;
    logic [3:0]        i_startOffset;
    logic              i_flush;
    logic [7:0]        i_room;
    logic              o_tableValid;
    logic              i_tableReady;
    logic [64*TS-1:0]  o_alignedInstructionTable;
    logic [7:0]        o_cutPostion_8;

    int checks = 0;
    int errors = 0;

    fetch_packer #(.TABLESIZE(TS), .ENTRYW(64)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .i_lineValid               (i_lineValid),
        .o_lineReady               (o_lineReady),
        .i_lineData                (i_lineData),
        .i_linePC                  (i_linePC),
        .i_startOffset             (i_startOffset),
        .i_flush                   (i_flush),
        .i_room                    (i_room),
        .o_tableValid              (o_tableValid),
        .i_tableReady              (i_tableReady),
        .o_alignedInstructionTable (o_alignedInstructionTable),
        .o_cutPostion_8            (o_cutPostion_8)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ent(input int j);
        return o_alignedInstructionTable[64*j +: 64];
    endfunction

    // Present one line for a single edge; called #1 after a posedge.
    task automatic offer_line(input logic [31:0] pc, input logic [3:0] off, input logic [31:0] base);
        for (int k = 0; k < TS; k++) i_lineData[32*k +: 32] = base + 32'(k);
        i_linePC      = pc;
        i_startOffset = off;
        i_lineValid   = 1'b1;
        @(posedge clk); #1;
        i_lineValid   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; i_lineValid = 0; i_lineData = '0; i_linePC = '0; i_startOffset = '0;
        i_flush = 0; i_room = 8'd0; i_tableReady = 0;
        #12;
        checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_tableValid); end
        checks++; if (o_cutPostion_8 !== 8'hFF) begin errors++; $display("FAIL reset_cut: got %h want ff", o_cutPostion_8); end
        checks++; if (o_alignedInstructionTable !== '0) begin errors++; $display("FAIL reset_table: got nonzero want 0"); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_lineReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_lineReady); end
    endtask

    task automatic test_full_line;
        i_room = 8'd10; i_tableReady = 1'b1;
        offer_line(32'h0000_1000, 4'd0, 32'hA000_0000);
        checks++; if (o_lineReady !== 1'b0) begin errors++; $display("FAIL full_busy: got %b want 0", o_lineReady); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", o_tableValid); end
        checks++; if (o_cutPostion_8 !== 8'd9) begin errors++; $display("FAIL full_cut: got %0d want 9", o_cutPostion_8); end
        checks++; if (ent(0) !== 64'h0000_1000_A000_0000) begin errors++; $display("FAIL full_e0: got %h want 00001000a0000000", ent(0)); end
        checks++; if (ent(9) !== 64'h0000_1024_A000_0009) begin errors++; $display("FAIL full_e9: got %h want 00001024a0000009", ent(9)); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL full_done_valid: got %b want 0", o_tableValid); end
        checks++; if (o_lineReady !== 1'b1) begin errors++; $display("FAIL full_idle: got %b want 1", o_lineReady); end
    endtask

    task automatic test_split_room;
        int starts [3] = '{2, 5, 8};
        int sizes  [3] = '{3, 3, 2};
        logic [63:0] exp;
        i_room = 8'd3; i_tableReady = 1'b1;
        offer_line(32'h0000_4000, 4'd2, 32'hB000_0000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (o_tableValid !== 1'b1) begin errors++; $display("FAIL split_valid%0d: got %b want 1", c, o_tableValid); end
            checks++; if (o_cutPostion_8 !== 8'(sizes[c] - 1)) begin errors++; $display("FAIL split_cut%0d: got %0d want %0d", c, o_cutPostion_8, sizes[c] - 1); end
            for (int j = 0; j < TS; j++) begin
                exp = (j < sizes[c]) ? {32'h0000_4000 + 32'(4 * (starts[c] + j)), 32'hB000_0000 + 32'(starts[c] + j)} : PAD;
                checks++; if (ent(j) !== exp) begin errors++; $display("FAIL split_c%0d_e%0d: got %h want %h", c, j, ent(j), exp); end
            end
        end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL split_end: got %b want 0", o_tableValid); end
    endtask

    task automatic test_stall;
        i_room = 8'd0; i_tableReady = 1'b0;
        offer_line(32'h0000_2000, 4'd0, 32'hC000_0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL stall_noroom%0d: got %b want 0", i, o_tableValid); end
        end
        i_room = 8'd4;
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b1 || o_cutPostion_8 !== 8'd3) begin errors++; $display("FAIL stall_first: got v=%b cut=%0d want v=1 cut=3", o_tableValid, o_cutPostion_8); end
        i_room = 8'd1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (o_tableValid !== 1'b1 || o_cutPostion_8 !== 8'd3) begin errors++; $display("FAIL stall_hold%0d: got v=%b cut=%0d want v=1 cut=3", i, o_tableValid, o_cutPostion_8); end
            checks++; if (ent(0) !== 64'h0000_2000_C000_0000 || ent(3) !== 64'h0000_200C_C000_0003) begin errors++; $display("FAIL stall_hold_data%0d: got %h %h", i, ent(0), ent(3)); end
        end
        i_room = 8'd4; i_tableReady = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_cutPostion_8 !== 8'd3 || ent(0) !== 64'h0000_2010_C000_0004) begin errors++; $display("FAIL stall_second: got cut=%0d e0=%h want 3 00002010c0000004", o_cutPostion_8, ent(0)); end
        @(posedge clk); #1;
        checks++; if (o_cutPostion_8 !== 8'd1 || ent(0) !== 64'h0000_2020_C000_0008) begin errors++; $display("FAIL stall_third: got cut=%0d e0=%h want 1 00002020c0000008", o_cutPostion_8, ent(0)); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0 || o_lineReady !== 1'b1) begin errors++; $display("FAIL stall_end: got v=%b rdy=%b want 0 1", o_tableValid, o_lineReady); end
    endtask

    task automatic test_flush;
        i_room = 8'd4; i_tableReady = 1'b1;
        offer_line(32'h0000_3000, 4'd0, 32'hD000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (o_cutPostion_8 !== 8'd3 || ent(0) !== 64'h0000_3010_D000_0004) begin errors++; $display("FAIL flush_chunk2: got cut=%0d e0=%h", o_cutPostion_8, ent(0)); end
        i_flush = 1'b1; i_tableReady = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        checks++; if (o_tableValid !== 1'b1 || o_cutPostion_8 !== 8'hFF) begin errors++; $display("FAIL flush_token: got v=%b cut=%h want 1 ff", o_tableValid, o_cutPostion_8); end
        checks++; if (o_alignedInstructionTable !== '0) begin errors++; $display("FAIL flush_table: got nonzero want 0"); end
        checks++; if (o_lineReady !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", o_lineReady); end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_cutPostion_8 !== 8'hFF || o_tableValid !== 1'b1 || o_lineReady !== 1'b0) begin errors++; $display("FAIL flush_hold: got v=%b cut=%h rdy=%b", o_tableValid, o_cutPostion_8, o_lineReady); end
        i_tableReady = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0 || o_lineReady !== 1'b1) begin errors++; $display("FAIL flush_exit: got v=%b rdy=%b want 0 1", o_tableValid, o_lineReady); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL flush_nodup: got %b want 0", o_tableValid); end
    endtask

    task automatic test_boundaries;
        i_room = 8'd15; i_tableReady = 1'b1;
        offer_line(32'hFFFF_FFF8, 4'd0, 32'hE000_0000);
        @(posedge clk); #1;
        checks++; if (o_cutPostion_8 !== 8'd9) begin errors++; $display("FAIL wrap_cut: got %0d want 9", o_cutPostion_8); end
        checks++; if (ent(2) !== 64'h0000_0000_E000_0002) begin errors++; $display("FAIL wrap_e2: got %h want 00000000e0000002", ent(2)); end
        checks++; if (ent(9) !== 64'h0000_001C_E000_0009) begin errors++; $display("FAIL wrap_e9: got %h want 0000001ce0000009", ent(9)); end
        @(posedge clk); #1;
        offer_line(32'h0000_6000, 4'd12, 32'hF000_0000);
        checks++; if (o_lineReady !== 1'b0) begin errors++; $display("FAIL empty_accept: got %b want 0", o_lineReady); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0 || o_lineReady !== 1'b1) begin errors++; $display("FAIL empty_idle: got v=%b rdy=%b want 0 1", o_tableValid, o_lineReady); end
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b0) begin errors++; $display("FAIL empty_none: got %b want 0", o_tableValid); end
    endtask

    task automatic test_reset_mid;
        i_room = 8'd3; i_tableReady = 1'b0;
        offer_line(32'h0000_5000, 4'd0, 32'h1234_0000);
        @(posedge clk); #1;
        checks++; if (o_tableValid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", o_tableValid); end
        rst = 1'b0; #2;
        checks++; if (o_tableValid !== 1'b0 || o_cutPostion_8 !== 8'hFF || o_alignedInstructionTable !== '0) begin errors++; $display("FAIL rmid_async: got v=%b cut=%h", o_tableValid, o_cutPostion_8); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_lineReady !== 1'b1 || o_tableValid !== 1'b0) begin errors++; $display("FAIL rmid_after: got rdy=%b v=%b want 1 0", o_lineReady, o_tableValid); end
    endtask

    initial begin
        test_reset;
        test_full_line;
        test_split_room;
        test_stall;
        test_flush;
        test_boundaries;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_packer.md
Name: fetch_packer

Overview:
- Producer side of the instruction-queue fill interface.
- Accepts one fetched 10-word instruction line with its base PC and start offset, and tags each word with its PC.
- Emits the line as one or more aligned tables of 64-bit {PC, instr} entries plus a cut position, never exceeding the free room the queue reports.
- Also emits the flush token (cut position 0xFF) on redirect.

Parameters:
- TABLESIZE, 10, entries per aligned table and words per fetch line.
- ENTRYW, 64, entry width: PC in [63:32], instruction in [31:0].

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- i_lineValid  in  1  fetch line offered.
- o_lineReady  out  1  packer can accept a line.
- i_lineData  in  32*TABLESIZE  word k at [32k+31:32k].
- i_linePC  in  32  PC of word 0; word k PC = i_linePC + 4k, modulo 2^32.
- i_startOffset  in  4  index of the first valid word.
- i_flush  in  1  redirect: discard everything and send the flush token.
- i_room  in  8  free entries in the queue.
- o_tableValid  out  1  table/cut valid.
- i_tableReady  in  1  queue consumes the table.
- o_alignedInstructionTable  out  ENTRYW*TABLESIZE  entry j at [64j+63:64j].
- o_cutPostion_8  out  8  (entries in table) - 1; 0xFF = flush token.

Behaviour:
- Reset (rst low, async): state IDLE, cursor 0, o_tableValid 0, table all-zero, o_cutPostion_8 = 0xFF. o_lineReady = 1 once rst is released.
- o_lineReady = (state==IDLE) & !i_flush, combinational.
- States: IDLE, EMIT, FLUSH.
- IDLE:
  - Line accept is i_lineValid & o_lineReady at posedge.
  - On accept: latch data, PC and cursor = i_startOffset; go to EMIT.
  - If i_startOffset >= TABLESIZE the line is empty: latch, then return to IDLE next cycle with no table emitted.
- EMIT chunk load:
  - Trigger: o_tableValid is 0, or a handshake (o_tableValid & i_tableReady) occurs with words remaining.
  - If trigger holds and the clamped room R = min(i_room, TABLESIZE) is nonzero, register a chunk.
  - Chunk size n = min(TABLESIZE - cursor, R).
  - Entry j<n = {i_linePC + 4*(cursor+j), word[cursor+j]}; entries j>=n = 0.
  - o_cutPostion_8 = n-1; o_tableValid = 1.
  - If R == 0: o_tableValid = 0 and wait.
- Output stability: table and cut are registered and held stable while o_tableValid & !i_tableReady. A change in i_room does not alter an offered chunk.
- Handshake: cursor += n.
  - If cursor == TABLESIZE: o_tableValid = 0 and go to IDLE.
  - Otherwise load the next chunk in the same edge, subject to R != 0.
- Latency:
  - Line accept at edge t: first chunk valid after edge t+1 if R != 0.
  - Back-to-back chunks have no bubble.
  - After the last handshake of a line, the earliest accept of the next line is the following edge.
- FLUSH:
  - Trigger: i_flush at any posedge in any state, highest priority.
  - Action: drop the latched line, register table = 0, cut = 0xFF, o_tableValid = 1, go to FLUSH.
  - Exit: hold until i_tableReady, then IDLE with o_tableValid = 0.
  - i_flush asserted again during FLUSH keeps one pending token; tokens never duplicate.
  - A flush on the same edge as a handshake: the handshake completes, then the token is registered.
- i_room > TABLESIZE is clamped to TABLESIZE. The cut position never exceeds TABLESIZE-1 except for the token.
- PC addition wraps modulo 2^32.
- Reset asserted mid-line or mid-flush: all state returns to reset values immediately, and any pending token is lost.

Optional Feature:
- Macro FETCH_PACKER_NOPPAD_EN.
- Defined: unused entries (j>n-1) carry 64'h0000_0000_0000_0013 (PC 0, addi x0,x0,0), matching the queue's nop padding. The flush token table is still all-zero.
- Undefined: unused entries are all-zero.

Test Plan:
- Reset:
  - Stimulus: rst low mid-EMIT, then released.
  - Required response: o_tableValid 0, cut 0xFF, table 0, and o_lineReady 1 in the next cycle.
- Full line:
  - Stimulus: line with PC 0x1000, offset 0, room 10, ready 1.
  - Required response: one table, cut 9; entry 0 = {0x1000, w0} and entry 9 = {0x1024, w9}; back to IDLE.
- Split by room:
  - Stimulus: offset 2, room 3, ready always 1.
  - Required response: chunks of cut 2, 2, 1 (words 2-4, 5-7, 8-9) on consecutive cycles.
  - Required response: entries 3..9 of each chunk are zero (0x13 pad with FETCH_PACKER_NOPPAD_EN).
- Stall:
  - Stimulus: room 0 for 5 cycles, then room 4, with ready held 0 for 2 cycles.
  - Required response: no valid during room 0; first chunk cut 3 held stable for 2 cycles even if room changes to 1.
- Flush:
  - Stimulus: i_flush during the second chunk.
  - Required response: next table has cut 0xFF and is all-zero; the remaining words are never emitted; o_lineReady stays 0 until the token handshake.
- Boundaries:
  - Stimulus: PC 0xFFFF_FFF8, offset 0, room 15.
  - Required response: single chunk cut 9; entry 2 PC = 0x0000_0000.
  - Stimulus: offset 12.
  - Required response: no table emitted; IDLE after one cycle.
